// File: rtl/ser_pkg.sv
// Shared constants for the serial receive controller:
// register addresses, STATUS/CTRL bit positions, default bit length.
package ser_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BITLEN = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_RDY  = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_FULL = 2;
  localparam int ST_CNT  = 8;

  localparam int CT_EN    = 0;
  localparam int CT_IE    = 1;
  localparam int CT_FLUSH = 2;

  localparam logic [15:0] BIT_LEN_DEF = 16'd434;

endpackage

// File: rtl/ser_fifo.sv
// DEPTH x 8 synchronous FIFO with push, pop and flush.
// Ports: clk, rst, push, pop, flush, din -> dout(head), full, empty, count.
module ser_fifo
  import ser_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_wr;
  logic w_rd;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  // When full, a push is only accepted if a pop frees the slot.
  assign w_wr = push & (~full | pop);
  assign w_rd = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush && !rst) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/ser_rcv_ctrl.sv
// Serial receiver controller: bit length, receiver reset, RX FIFO,
// CPU register file (DATA/STATUS/BITLEN/CTRL) and level interrupt.
module ser_rcv_ctrl
  import ser_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] BIT_LEN_RST = BIT_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rcv_full,
  input  logic [7:0]  rcv_data,
  output logic        rcv_rst,
  output logic [15:0] bit_len,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          r_en;
  logic          r_ie;
  logic          r_ovr;
  logic [15:0]   r_bit_len;
  logic          r_bitlen_wr_q;

  logic          w_rcv_rst;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_wr_stat;
  logic          w_wr_blen;
  logic          w_wr_ctrl;
  logic          w_ovr_set;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_cnt32;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_wr_stat = stb & we & (addr == ADDR_STATUS);
  assign w_wr_blen = stb & we & (addr == ADDR_BITLEN);
  assign w_wr_ctrl = stb & we & (addr == ADDR_CTRL);
  assign w_pop     = stb & ~we & (addr == ADDR_DATA);
  assign w_flush   = w_wr_ctrl & data_in[CT_FLUSH];

  // Receiver held in reset while disabled and for one cycle
  // after each rate change so it restarts at the new bit length.
  assign w_rcv_rst = rst | ~r_en | r_bitlen_wr_q;
  assign rcv_rst   = w_rcv_rst;
  assign bit_len   = r_bit_len;

  assign w_push = rcv_full & r_en & ~w_rcv_rst;

  // A pop in the same cycle frees a slot, so no overrun then.
  assign w_ovr_set = w_push & w_full & ~w_pop & ~w_flush;

  ser_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (rcv_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en          <= 1'b0;
      r_ie          <= 1'b0;
      r_ovr         <= 1'b0;
      r_bit_len     <= BIT_LEN_RST;
      r_bitlen_wr_q <= 1'b0;
    end else begin
      r_bitlen_wr_q <= w_wr_blen;
      if (w_wr_blen) r_bit_len <= data_in[15:0];
      if (w_wr_ctrl) begin
        r_en <= data_in[CT_EN];
        r_ie <= data_in[CT_IE];
      end
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (w_wr_stat && data_in[ST_OVR])
        r_ovr <= 1'b0;
    end
  end

  assign w_cnt32 = 32'(w_count);

  always_comb begin
    w_status          = '0;
    w_status[ST_RDY]  = ~w_empty;
    w_status[ST_OVR]  = r_ovr;
    w_status[ST_FULL] = w_full;
    w_status[ST_CNT+:8] = w_cnt32[7:0];
  end

  always_comb begin
    data_out = '0;
    unique case (addr)
      ADDR_DATA:   data_out = w_empty ? 32'd0 : {24'd0, w_head};
      ADDR_STATUS: data_out = w_status;
      ADDR_BITLEN: data_out = {16'd0, r_bit_len};
      ADDR_CTRL:   data_out = {30'd0, r_ie, r_en};
    endcase
  end

  assign irq = r_ie & (~w_empty | r_ovr);

  assign w_unused = ^{data_in[31:16], w_cnt32[31:8]};

endmodule

// File: tb/tb_ser_rcv_ctrl.sv
// Scoreboard bench for ser_rcv_ctrl: stimulus queues expected values,
// a negedge monitor pops and compares on reads and probes.
module tb_ser_rcv_ctrl;

  localparam int K_RD   = 0;
  localparam int K_IRQ  = 1;
  localparam int K_RRST = 2;
  localparam int K_BLEN = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rcv_full = 1'b0;
  logic [7:0]  rcv_data = '0;
  logic        rcv_rst;
  logic [15:0] bit_len;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        irq;
  logic        probe = 1'b0;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ser_rcv_ctrl #(.DEPTH(16), .BIT_LEN_RST(16'd434)) dut (
    .clk      (clk),
    .rst      (rst),
    .rcv_full (rcv_full),
    .rcv_data (rcv_data),
    .rcv_rst  (rcv_rst),
    .bit_len  (bit_len),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input int k, input logic [31:0] act);
    exp_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected output kind=%0d: got %h, no expectation", k, act);
    end else begin
      e = q.pop_front();
      if (e.kind != k || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h (kind %0d), expected %h (kind %0d)",
                 e.name, act, k, e.exp, e.kind);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && stb && !we) check(K_RD, data_out);
    if (probe && q.size() > 0) begin
      case (q[0].kind)
        K_IRQ:   check(K_IRQ, {31'd0, irq});
        K_RRST:  check(K_RRST, {31'd0, rcv_rst});
        default: check(K_BLEN, {16'd0, bit_len});
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string n);
    push_exp(K_RD, v, n);
    stb = 1'b1; we = 1'b0; addr = a;
    cyc();
    stb = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    cyc();
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rcv_full = 1'b1; rcv_data = b;
    cyc();
    rcv_full = 1'b0;
  endtask

  task automatic chk(input int k, input logic [31:0] v, input string n);
    push_exp(k, v, n);
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    rd(2'd1, 32'h0, "rst_status");
    rd(2'd2, 32'd434, "rst_bitlen");
    rd(2'd3, 32'h0, "rst_ctrl");
    rd(2'd0, 32'h0, "rst_data_empty");
    chk(K_IRQ, 32'd0, "rst_irq");
    chk(K_RRST, 32'd1, "rst_rcv_rst");

    wr(2'd3, 32'h3);
    chk(K_RRST, 32'd0, "en_rcv_rst");
    rx(8'h41); rx(8'h42); rx(8'h43);
    rd(2'd1, 32'h0301, "three_status");
    chk(K_IRQ, 32'd1, "three_irq");
    rd(2'd0, 32'h41, "pop_41");
    rd(2'd0, 32'h42, "pop_42");
    rd(2'd0, 32'h43, "pop_43");
    rd(2'd1, 32'h0, "drained_status");
    chk(K_IRQ, 32'd0, "drained_irq");

    for (int i = 0; i < 17; i++) rx(8'(i));
    rd(2'd1, 32'h1007, "full_ovr_status");
    wr(2'd1, 32'h2);
    rd(2'd1, 32'h1005, "ovr_cleared");

    // Full FIFO: pop and push in the same cycle.
    push_exp(K_RD, 32'h00, "pop_push_00");
    stb = 1'b1; we = 1'b0; addr = 2'd0;
    rcv_full = 1'b1; rcv_data = 8'h55;
    cyc();
    stb = 1'b0; rcv_full = 1'b0;
    rd(2'd1, 32'h1005, "pop_push_status");
    for (int i = 1; i < 16; i++) rd(2'd0, 32'(i), "drain_full");
    rd(2'd0, 32'h55, "last_55");
    rd(2'd1, 32'h0, "after_drain");

    wr(2'd2, 32'h0100);
    chk(K_RRST, 32'd1, "blen_rcv_rst_pulse");
    chk(K_RRST, 32'd0, "blen_rcv_rst_end");
    chk(K_BLEN, 32'h0100, "bit_len_out");
    rd(2'd2, 32'h0100, "bitlen_read");

    for (int i = 1; i <= 5; i++) rx(8'(i));
    rd(2'd1, 32'h0501, "five_status");
    stb = 1'b1; we = 1'b1; addr = 2'd3; data_in = 32'h7;
    rcv_full = 1'b1; rcv_data = 8'h99;
    cyc();
    stb = 1'b0; we = 1'b0; rcv_full = 1'b0;
    rd(2'd1, 32'h0, "flush_status");
    rd(2'd3, 32'h3, "flush_ctrl");
    rd(2'd0, 32'h0, "empty_data");
    rd(2'd1, 32'h0, "empty_read_status");
    rx(8'h77);
    rd(2'd0, 32'h77, "post_flush_77");

    wr(2'd3, 32'h2);
    chk(K_RRST, 32'd1, "dis_rcv_rst");
    rx(8'h12);
    rd(2'd1, 32'h0, "dis_ignored");

    wr(2'd3, 32'h1);
    rx(8'h33);
    rd(2'd1, 32'h0101, "pre_rst_status");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd(2'd1, 32'h0, "post_rst_status");
    rd(2'd2, 32'd434, "post_rst_bitlen");
    rd(2'd3, 32'h0, "post_rst_ctrl");

    cyc();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
